// File: rtl/int_alu_sequencer.sv
// int_alu_sequencer: bus master that owns a 12 x 256-bit memory and runs the ALU.
// For each command it writes the A and B operands and the opcode into the ALU
// window. It then waits ALU_LAT cycles, reads the result back and writes it to
// mem[Dst].
// Optional build macro SEQ_CMD_QUEUE_EN adds a 2-entry command FIFO. Without it,
// a Start that arrives while busy is dropped and Err is pulsed.
module int_alu_sequencer #(
   parameter int unsigned  ALU_LAT  = 4,
   parameter logic [15:0]  ALU_BASE = 16'h1000
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [3:0]   Opcode,
   input  logic [3:0]   SrcA,
   input  logic [3:0]   SrcB,
   input  logic [3:0]   Dst,
   input  logic         LdEn,
   input  logic [3:0]   LdAddr,
   input  logic [255:0] LdData,
   input  logic [3:0]   DbgAddr,
   output logic [255:0] DbgData,
   output logic [15:0]  address,
   output logic [255:0] DataOut,
   input  logic [255:0] AluDataIn,
   output logic         nRead,
   output logic         nWrite,
   output logic         Busy,
   output logic         Done,
   output logic         Err
);

   localparam int unsigned NWORDS = 12;

   typedef enum logic [3:0] {
      S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_WAIT, S_RD_RES, S_CAP, S_WB, S_DONE
   } state_t;

   state_t        state;
   logic [255:0]  mem [NWORDS];
   logic [3:0]    op_reg, src_a_reg, src_b_reg, dst_reg;
   logic [255:0]  result_reg;
   logic [3:0]    wait_cnt;

   logic          cmd_valid;
   logic          ld_ok;
   logic          launch;
   logic          reject_busy;
   logic          pop;
   logic [15:0]   new_cmd;
   logic [15:0]   q_head;
   logic [15:0]   launch_cmd;
   logic [255:0]  launch_a_data;

   assign cmd_valid = (SrcA < 4'd12) && (SrcB < 4'd12) && (Dst < 4'd12);
   assign ld_ok     = LdEn && (state == S_IDLE) && (LdAddr < 4'd12);
   assign new_cmd   = {Opcode, SrcA, SrcB, Dst};

`ifdef SEQ_CMD_QUEUE_EN
   logic [15:0] q_mem [2];
   logic [1:0]  q_count;
   logic        push;

   assign push        = Start && (state != S_IDLE) && cmd_valid && (q_count != 2'd2);
   assign pop         = (state == S_DONE) && (q_count != 2'd0);
   assign reject_busy = Start && (state != S_IDLE) && !push;
   assign q_head      = q_mem[0];

   // Command FIFO: q_mem[0] is always the head; a push during a pop lands in slot 0.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q_count  <= 2'd0;
         q_mem[0] <= '0;
         q_mem[1] <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               q_mem[q_count[0]] <= new_cmd;
               q_count           <= q_count + 2'd1;
            end
            2'b01: begin
               q_mem[0] <= q_mem[1];
               q_count  <= q_count - 2'd1;
            end
            2'b11:   q_mem[0] <= new_cmd;
            default: ;
         endcase
      end
   end
`else
   assign pop         = 1'b0;
   assign reject_busy = Start && (state != S_IDLE);
   assign q_head      = '0;
`endif

   // Select the command about to start. A preload on the same edge is forwarded
   // into operand A.
   always_comb begin
      launch_cmd    = new_cmd;
      launch_a_data = '0;
      if (state == S_DONE)
         launch_cmd = q_head;
      if (launch_cmd[11:8] < 4'd12)
         launch_a_data = mem[launch_cmd[11:8]];
      if (ld_ok && (LdAddr == launch_cmd[11:8]))
         launch_a_data = LdData;
   end

   assign launch = ((state == S_IDLE) && Start && cmd_valid) || pop;

   // Readback port: out-of-range indices read as zero.
   always_comb begin
      DbgData = '0;
      if (DbgAddr < 4'd12)
         DbgData = mem[DbgAddr];
   end

   // Memory: the writeback in WB takes priority; host preload is only possible in IDLE.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NWORDS; i++)
            mem[i] <= '0;
      end else if (state == S_WB) begin
         mem[dst_reg] <= result_reg;
      end else if (ld_ok) begin
         mem[LdAddr] <= LdData;
      end
   end

   // Sequencer FSM. Bus outputs are registered, and each one is set on the edge
   // that enters the state it belongs to.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= S_IDLE;
         address    <= '0;
         DataOut    <= '0;
         nRead      <= 1'b1;
         nWrite     <= 1'b1;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Err        <= 1'b0;
         op_reg     <= '0;
         src_a_reg  <= '0;
         src_b_reg  <= '0;
         dst_reg    <= '0;
         result_reg <= '0;
         wait_cnt   <= '0;
      end else begin
         nRead   <= 1'b1;
         nWrite  <= 1'b1;
         address <= '0;
         DataOut <= '0;
         Done    <= 1'b0;
         Err     <= ((state == S_IDLE) && Start && !cmd_valid) || reject_busy;
         case (state)
            S_IDLE, S_DONE: begin
               if (launch) begin
                  {op_reg, src_a_reg, src_b_reg, dst_reg} <= launch_cmd;
                  nWrite  <= 1'b0;
                  address <= ALU_BASE;
                  DataOut <= launch_a_data;
                  Busy    <= 1'b1;
                  state   <= S_WR_A;
               end else begin
                  Busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_WR_A: begin
               nWrite  <= 1'b0;
               address <= ALU_BASE + 16'd1;
               DataOut <= mem[src_b_reg];
               state   <= S_WR_B;
            end
            S_WR_B: begin
               nWrite  <= 1'b0;
               address <= ALU_BASE + 16'd2;
               DataOut <= {252'b0, op_reg};
               state   <= S_WR_OP;
            end
            S_WR_OP: begin
               wait_cnt <= 4'(ALU_LAT - 1);
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  nRead   <= 1'b0;
                  address <= ALU_BASE + 16'd3;
                  state   <= S_RD_RES;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_RD_RES: state <= S_CAP;
            S_CAP: begin
               result_reg <= AluDataIn;
               state      <= S_WB;
            end
            S_WB: begin
               Done  <= 1'b1;
               state <= S_DONE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_alu_sequencer.sv
// Directed testbench for int_alu_sequencer. It uses a behavioural ALU stub that
// returns A+B one cycle after the result read.
module tb_int_alu_sequencer;

   localparam int          LAT  = 4;
   localparam logic [15:0] BASE = 16'h1000;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic         Start = 1'b0;
   logic [3:0]   Opcode = '0, SrcA = '0, SrcB = '0, Dst = '0;
   logic         LdEn = 1'b0;
   logic [3:0]   LdAddr = '0;
   logic [255:0] LdData = '0;
   logic [3:0]   DbgAddr = '0;
   logic [255:0] DbgData;
   logic [15:0]  address;
   logic [255:0] DataOut;
   logic [255:0] AluDataIn;
   logic         nRead, nWrite, Busy, Done, Err;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   int clash_cnt = 0;
   int d0;

   logic [255:0] alu_a = '0, alu_b = '0, alu_res = '0;

   int_alu_sequencer #(.ALU_LAT(LAT), .ALU_BASE(BASE)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode),
      .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst),
      .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData),
      .DbgAddr(DbgAddr), .DbgData(DbgData),
      .address(address), .DataOut(DataOut), .AluDataIn(AluDataIn),
      .nRead(nRead), .nWrite(nWrite), .Busy(Busy), .Done(Done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   // ALU stub: latches the operands on writes and registers A+B on the result read.
   assign AluDataIn = alu_res;
   always @(posedge Clk) begin
      if (!nWrite && address == BASE)            alu_a   <= DataOut;
      if (!nWrite && address == BASE + 16'd1)    alu_b   <= DataOut;
      if (!nRead  && address == BASE + 16'd3)    alu_res <= alu_a + alu_b;
   end

   // Count Done pulses and both-strobes-low cycles.
   always @(negedge Clk) begin
      if (Done === 1'b1) done_cnt <= done_cnt + 1;
      if (nRead === 1'b0 && nWrite === 1'b0) clash_cnt <= clash_cnt + 1;
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic drive_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
      Opcode = op; SrcA = a; SrcB = b; Dst = d; Start = 1'b1;
   endtask

   task automatic preload(input logic [3:0] idx, input logic [255:0] val);
      LdEn = 1'b1; LdAddr = idx; LdData = val;
      @(negedge Clk);
      LdEn = 1'b0;
   endtask

   task automatic dbg_chk(input string tag, input logic [3:0] idx, input logic [255:0] exp);
      DbgAddr = idx;
      #1;
      chk(tag, DbgData, exp);
   endtask

   // Issue one command and check the bus timeline from cycle 1 to cycle 12.
   task automatic run_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d, input logic ld, input logic [3:0] ld_idx,
                          input logic [255:0] ld_val, input logic [255:0] ea,
                          input logic [255:0] eb);
      $display("txn op=%0d srcA=%0d srcB=%0d dst=%0d preload=%0d", op, a, b, d, ld);
      drive_cmd(op, a, b, d);
      if (ld) begin LdEn = 1'b1; LdAddr = ld_idx; LdData = ld_val; end
      @(negedge Clk); Start = 1'b0; LdEn = 1'b0;          // cycle 1
      chk("wra_strobe", {nRead, nWrite}, 2'b10);
      chk("wra_addr", address, BASE);
      chk("wra_data", DataOut, ea);
      chk("busy_c1", Busy, 1'b1);
      @(negedge Clk);                                      // cycle 2
      chk("wrb_strobe", {nRead, nWrite}, 2'b10);
      chk("wrb_addr", address, BASE + 16'd1);
      chk("wrb_data", DataOut, eb);
      @(negedge Clk);                                      // cycle 3
      chk("wrop_strobe", {nRead, nWrite}, 2'b10);
      chk("wrop_addr", address, BASE + 16'd2);
      chk("wrop_data", DataOut, {252'b0, op});
      for (int c = 4; c <= 3 + LAT; c++) begin
         @(negedge Clk);
         chk("wait_strobe", {nRead, nWrite}, 2'b11);
      end
      @(negedge Clk);                                      // cycle 8
      chk("rd_strobe", {nRead, nWrite}, 2'b01);
      chk("rd_addr", address, BASE + 16'd3);
      @(negedge Clk);                                      // cycle 9
      chk("cap_addr", address, 16'h0);
      @(negedge Clk);                                      // cycle 10
      chk("done_early", Done, 1'b0);
      @(negedge Clk);                                      // cycle 11
      chk("done_c11", Done, 1'b1);
      chk("busy_c11", Busy, 1'b1);
      @(negedge Clk);                                      // cycle 12
      chk("done_c12", Done, 1'b0);
      chk("busy_c12", Busy, 1'b0);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_addr", address, 16'h0);
      chk("rst_data", DataOut, '0);
      chk("rst_strobe", {nRead, nWrite}, 2'b11);
      chk("rst_flags", {Busy, Done, Err}, 3'b000);
      dbg_chk("rst_mem0", 4'd0, '0);
      @(negedge Clk); Reset = 1'b0;
      @(negedge Clk);

      // Basic add: 5 + 7 -> mem[2]
      preload(4'd0, 256'd5);
      preload(4'd1, 256'd7);
      run_cmd(4'd0, 4'd0, 4'd1, 4'd2, 1'b0, 4'd0, '0, 256'd5, 256'd7);
      dbg_chk("basic_res", 4'd2, 256'd12);
      dbg_chk("dbg_oob", 4'd15, '0);

      // Invalid destination index
      $display("txn invalid dst=12");
      @(negedge Clk);
      drive_cmd(4'd0, 4'd0, 4'd1, 4'd12);
      @(negedge Clk); Start = 1'b0;
      chk("inv_err", Err, 1'b1);
      chk("inv_busy", Busy, 1'b0);
      chk("inv_strobe", {nRead, nWrite}, 2'b11);
      @(negedge Clk);
      chk("inv_err_clr", Err, 1'b0);
      chk("inv_strobe2", {nRead, nWrite}, 2'b11);
      dbg_chk("inv_mem2", 4'd2, 256'd12);

      // Aliasing: SrcA = Dst = 3
      @(negedge Clk);
      preload(4'd3, 256'd9);
      preload(4'd4, 256'd1);
      run_cmd(4'd0, 4'd3, 4'd4, 4'd3, 1'b0, 4'd0, '0, 256'd9, 256'd1);
      dbg_chk("alias_res", 4'd3, 256'd10);

      // Preload on the same edge as Start
      @(negedge Clk);
      run_cmd(4'd0, 4'd0, 4'd1, 4'd5, 1'b1, 4'd0, 256'hFF, 256'hFF, 256'd7);
      dbg_chk("race_mem0", 4'd0, 256'hFF);
      dbg_chk("race_res", 4'd5, 256'h106);

      // Busy collision: second Start in cycle 5, plus a preload that must be ignored
      $display("txn collision first dst=7 second dst=8");
      @(negedge Clk);
      d0 = done_cnt;
      drive_cmd(4'd0, 4'd0, 4'd1, 4'd7);
      @(negedge Clk); Start = 1'b0;                        // cycle 1
      repeat (4) @(negedge Clk);                           // cycle 5
      drive_cmd(4'd0, 4'd3, 4'd4, 4'd8);
      LdEn = 1'b1; LdAddr = 4'd6; LdData = 256'hAB;
      @(negedge Clk); Start = 1'b0; LdEn = 1'b0;           // cycle 6
`ifdef SEQ_CMD_QUEUE_EN
      chk("coll_err", Err, 1'b0);
`else
      chk("coll_err", Err, 1'b1);
`endif
      for (int c = 7; c <= 25; c++) begin
         @(negedge Clk);
         if (c == 12) begin
`ifdef SEQ_CMD_QUEUE_EN
            chk("q_wra_strobe", {nRead, nWrite}, 2'b10);
            chk("q_wra_data", DataOut, 256'd10);
            chk("q_busy", Busy, 1'b1);
`else
            chk("coll_strobe", {nRead, nWrite}, 2'b11);
            chk("coll_busy", Busy, 1'b0);
`endif
         end
      end
      #1;
`ifdef SEQ_CMD_QUEUE_EN
      chk("coll_dones", done_cnt - d0, 2);
      dbg_chk("coll_mem8", 4'd8, 256'd11);
`else
      chk("coll_dones", done_cnt - d0, 1);
      dbg_chk("coll_mem8", 4'd8, '0);
`endif
      dbg_chk("coll_mem7", 4'd7, 256'h106);
      dbg_chk("busy_ld_ignored", 4'd6, '0);

      // Reset in the middle of WAIT
      $display("txn reset during wait");
      @(negedge Clk);
      DbgAddr = 4'd0;
      d0 = done_cnt;
      drive_cmd(4'd0, 4'd0, 4'd1, 4'd9);
      @(negedge Clk); Start = 1'b0;                        // cycle 1
      repeat (4) @(negedge Clk);                           // cycle 5
      chk("pre_rst_busy", Busy, 1'b1);
      #2 Reset = 1'b1;
      #1;
      chk("mid_rst_strobe", {nRead, nWrite}, 2'b11);
      chk("mid_rst_busy", Busy, 1'b0);
      chk("mid_rst_mem0", DbgData, '0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (15) @(negedge Clk);
      #1;
      chk("mid_rst_nodone", done_cnt - d0, 0);
      dbg_chk("mid_rst_mem9", 4'd9, '0);

      chk("strobe_clash", clash_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
